coin_change_dispenser: RTL

- Refund/change side of the haircut vending machine.
- Takes a credit amount from the vending FSM over a valid/ready handshake.
- Pays it out as paced one-hot pulses on three coin-ejector lines (2, 5, 10 units), mirroring the machine's coin-input buttons in the opposite direction.
- Flags amounts that cannot be paid with {2,5,10}, and reports completion.

---
 rtl/vending_pkg.sv | 44 ++++
 rtl/coin_change_dispenser_pulse_timer.sv | 27 ++
 rtl/coin_change_dispenser.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared encodings for the vending machine change path: FSM states, coin values and one-hot coin selects.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] COIN2_VAL  = 4'd2;
  localparam logic [3:0] COIN5_VAL  = 4'd5;
  localparam logic [3:0] COIN10_VAL = 4'd10;

  // Bit order matches the ejector bus {coin10, coin5, coin2}.
  typedef enum logic [2:0] {
    SEL_NONE = 3'b000,
    SEL_2    = 3'b001,
    SEL_5    = 3'b010,
    SEL_10   = 3'b100
  } coin_sel_t;

  // One 5 first clears odd amounts, then 10s while they fit, then 2s.
  function automatic coin_sel_t select_coin(input logic [15:0] amt);
    if (amt[0]) begin
      return SEL_5;
    end else if (amt >= 16'd10) begin
      return SEL_10;
    end else begin
      return SEL_2;
    end
  endfunction

  function automatic logic [3:0] coin_value(input coin_sel_t sel);
    case (sel)
      SEL_2:   return COIN2_VAL;
      SEL_5:   return COIN5_VAL;
      SEL_10:  return COIN10_VAL;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_change_dispenser_pulse_timer.sv
// Loadable down-counter for coin pulse/gap pacing; tc is high while the count sits at zero.
// A load of N gives N+1 cycles until tc, so callers load (cycles - 1).
module pulse_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/coin_change_dispenser.sv
// Refund dispenser: accepts one amount in IDLE (no queueing), pays it as paced one-hot coin pulses; done at T+2+n*(PULSE_CYC+GAP_CYC).
// Optional CHANGE_STATS_EN adds a saturating total_paid counter with synchronous stats_clr.
module coin_change_dispenser
  import vending_pkg::*;
#(
  parameter int AMT_W     = 6,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             coin2,
  output logic             coin5,
  output logic             coin10,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
`ifdef CHANGE_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      total_paid
`endif
);

  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

  state_t           state;
  coin_sel_t        next_sel;
  coin_sel_t        cur_sel;
  logic [AMT_W-1:0] cur_val;
  logic             payable;
  logic             tc;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;

  assign next_sel = select_coin(16'(remaining));
  // The coin lines are only non-zero in PULSE, so they double as the held selection.
  assign cur_sel  = coin_sel_t'({coin10, coin5, coin2});
  assign cur_val  = AMT_W'(coin_value(cur_sel));
  assign payable  = (remaining != '0) && (remaining != AMT_W'(1)) && (remaining != AMT_W'(3));

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state)
      ST_CHECK: tmr_load = payable;
      ST_PULSE: begin
        tmr_load = tc;
        tmr_val  = GAP_LD;
      end
      ST_GAP:   tmr_load = tc && (remaining != '0);
      default:  tmr_load = 1'b0;
    endcase
  end

  pulse_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      coin2     <= 1'b0;
      coin5     <= 1'b0;
      coin10    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            remaining <= req_amount;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (payable) begin
            {coin10, coin5, coin2} <= next_sel;
            state <= ST_PULSE;
          end else begin
            // Zero completes cleanly; 1 and 3 are unpayable and keep their amount visible.
            done  <= 1'b1;
            err   <= (remaining != '0);
            state <= ST_DONE;
          end
        end
        ST_PULSE: begin
          if (tc) begin
            {coin10, coin5, coin2} <= SEL_NONE;
            remaining <= remaining - cur_val;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tc) begin
            if (remaining == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              {coin10, coin5, coin2} <= next_sel;
              state <= ST_PULSE;
            end
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          {coin10, coin5, coin2} <= SEL_NONE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CHANGE_STATS_EN
  logic [15:0] inc_val;

  assign inc_val = 16'(coin_value(cur_sel));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_paid <= '0;
    end else if (stats_clr) begin
      total_paid <= '0;
    end else if ((state == ST_PULSE) && tc) begin
      total_paid <= (total_paid > (16'hFFFF - inc_val)) ? 16'hFFFF : (total_paid + inc_val);
    end
  end
`endif

  a_coin_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({coin10, coin5, coin2}));
  a_err_with_done: assert property (@(posedge clk) disable iff (!rst)
    err |-> done);

endmodule
